// File: rtl/vga_pkg.sv
// Shared timing defaults, RGB444 field positions and the stage-0 control bundle
// used by the VGA scan controller and its sync generator.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 56;
  localparam int unsigned DEF_H_SYNC   = 120;
  localparam int unsigned DEF_H_BP     = 64;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 37;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 23;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned R_MSB = 11;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned G_MSB = 7;
  localparam int unsigned G_LSB = 4;
  localparam int unsigned B_MSB = 3;
  localparam int unsigned B_LSB = 0;

  // Per-pixel control bits that travel down the alignment pipeline together.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic sof;
  } vga_ctl_t;

  // Counter width able to hold every value up to and including 'total'.
  function automatic int unsigned cnt_width(input int unsigned total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical raster counters and the stage-0 decode of active video,
// sync pulses and start-of-frame.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic     pclk,
  input  logic     resetn,
  output vga_ctl_t ctl0,
  output logic     vblank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = cnt_width(H_TOTAL);
  localparam int unsigned VW = cnt_width(V_TOTAL);

  // One extra counter bit keeps the exclusive sync-end bound representable.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_wrap) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + VW'(1);
    end else begin
      h_cnt_reg <= h_cnt_reg + HW'(1);
    end
  end

  always_comb begin
    ctl0     = '0;
    ctl0.act = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    ctl0.hs  = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
    ctl0.vs  = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    ctl0.sof = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  // Raw line-counter view for software polling; deliberately not pipelined.
  assign vblank = (v_cnt_reg >= V_VIS);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: linear video-memory address generation plus a 3-stage
// pipeline that realigns returned RGB444 pixels with sync and blanking.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned VMEM_ADDR_WIDTH = 19,
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned H_FP            = DEF_H_FP,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BP            = DEF_H_BP,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned V_FP            = DEF_V_FP,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BP            = DEF_V_BP,
  parameter logic        HS_POL          = 1'b1,
  parameter logic        VS_POL          = 1'b1
) (
  input  logic                       pclk,
  input  logic                       resetn,
  output logic [VMEM_ADDR_WIDTH-1:0] vmem_r_addr,
  input  logic [RGB_W-1:0]           vga_rdata,
  output logic [3:0]                 vga_r,
  output logic [3:0]                 vga_g,
  output logic [3:0]                 vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_de,
  output logic                       frame_start,
  output logic                       vblank
);

  // pix reaches H_ACTIVE*V_ACTIVE after the last visible pixel, which may be 2^W.
  localparam int unsigned PW = VMEM_ADDR_WIDTH + 1;

  vga_ctl_t                   ctl0;
  vga_ctl_t                   ctl1_reg;
  vga_ctl_t                   ctl2_reg;
  logic [PW-1:0]              pix_reg;
  logic [VMEM_ADDR_WIDTH-1:0] addr_reg;
  logic [RGB_W-1:0]           rgb_reg;
  logic                       hs_reg;
  logic                       vs_reg;
  logic                       de_reg;
  logic                       fs_reg;

  vga_sync_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_gen (
    .pclk   (pclk),
    .resetn (resetn),
    .ctl0   (ctl0),
    .vblank (vblank)
  );

  // Incrementing pixel index avoids a v*H_ACTIVE+h multiplier.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      addr_reg <= '0;
      pix_reg  <= '0;
    end else if (ctl0.sof) begin
      addr_reg <= '0;
      pix_reg  <= PW'(1);
    end else if (ctl0.act) begin
      addr_reg <= pix_reg[VMEM_ADDR_WIDTH-1:0];
      pix_reg  <= pix_reg + PW'(1);
    end
  end

  assign vmem_r_addr = addr_reg;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      ctl1_reg <= '0;
      ctl2_reg <= '0;
    end else begin
      ctl1_reg <= ctl0;
      ctl2_reg <= ctl1_reg;
    end
  end

  // Blanking data from memory is discarded here so it never reaches the pins.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      rgb_reg <= '0;
      hs_reg  <= ~HS_POL;
      vs_reg  <= ~VS_POL;
      de_reg  <= 1'b0;
      fs_reg  <= 1'b0;
    end else begin
      rgb_reg <= ctl2_reg.act ? vga_rdata : '0;
      hs_reg  <= ctl2_reg.hs ? HS_POL : ~HS_POL;
      vs_reg  <= ctl2_reg.vs ? VS_POL : ~VS_POL;
      de_reg  <= ctl2_reg.act;
      fs_reg  <= ctl2_reg.sof;
    end
  end

  assign vga_r       = rgb_reg[R_MSB:R_LSB];
  assign vga_g       = rgb_reg[G_MSB:G_LSB];
  assign vga_b       = rgb_reg[B_MSB:B_LSB];
  assign vga_hs      = hs_reg;
  assign vga_vs      = vs_reg;
  assign vga_de      = de_reg;
  assign frame_start = fs_reg;

endmodule
